// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: one-outstanding-request fetch engine feeding a
// circular FIFO of {instr, pc_next} entries, with redirect flush support.
module instruction_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        consume,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e             state_q;
    logic [31:0]        fetch_pc_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        pcn_q   [DEPTH];

    logic not_full;
    logic not_empty;
    logic accept;
    logic push;
    logic pop;

    // Request and head outputs depend only on registered state.
    assign not_full    = count_q < CNT_W'(DEPTH);
    assign not_empty   = count_q != '0;
    assign mem_req     = (state_q == FETCH) && not_full;
    assign mem_addr    = fetch_pc_q;
    assign out_valid   = not_empty;
    assign out_instr   = not_empty ? instr_q[head_q] : 32'h0;
    assign out_pc_next = not_empty ? pcn_q[head_q]   : 32'h0;

    assign accept = mem_req && mem_ready;
    assign push   = (state_q == WAIT) && mem_rvalid && !redirect;
    assign pop    = consume && not_empty && !redirect;

    // In WAIT fetch_pc already holds the request address + 4.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            instr_q[tail_q] <= mem_rdata;
            pcn_q[tail_q]   <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        state_q <= redirect ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= FETCH;
                    end else if (redirect) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (mem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase

            if (redirect) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            // Redirect flushes everything; otherwise push/pop move the pointers.
            if (redirect) begin
                count_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
            end else begin
                if (push) begin
                    tail_q <= tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_q <= head_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: directed vector table, directed fill/wrap
// sequence, and randomized traffic against a queue-based reference model.
module tb_instruction_prefetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        consume;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    instruction_prefetch_buffer #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .consume    (consume),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc_next(out_pc_next),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        cons;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcn;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcn;
    } ent_t;

    // Reference model: FIFO contents plus the one outstanding request.
    ent_t        mq[$];
    logic [31:0] m_fpc;
    bit          m_busy;
    bit          m_stale;
    logic [31:0] m_reqpc;
    int          m_lat;
    int          lat_max;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic compare_out(input string name, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic er, input logic [31:0] ea);
        bit bad;
        vecs++;
        bad = (out_valid !== ev) || (out_instr !== ei) || (out_pc_next !== ep) ||
              (mem_req !== er) || (er && (mem_addr !== ea));
        if (bad) begin
            fails++;
            $display("FAIL %s t=%0t: got valid=%0b instr=%08h pcn=%08h req=%0b addr=%08h, want valid=%0b instr=%08h pcn=%08h req=%0b addr=%08h",
                     name, $time, out_valid, out_instr, out_pc_next, mem_req, mem_addr,
                     ev, ei, ep, er, ea);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %08h want %08h", name, got, want);
        end
    endtask

    // One clock of model-driven memory plus the given control inputs.
    task automatic tick(input bit rst_n_v, input bit redir, input logic [31:0] rpc,
                        input bit cons, input bit rdy);
        bit          rv;
        bit          m_req;
        bit          acc;
        logic [31:0] e_i;
        logic [31:0] e_p;
        rv          = m_busy && (m_lat == 0);
        reset       = rst_n_v;
        redirect    = redir;
        redirect_pc = rpc;
        consume     = cons;
        mem_ready   = rdy;
        mem_rvalid  = rv;
        mem_rdata   = rv ? mem_fn(m_reqpc) : $urandom;
        @(posedge clk);
        #1;
        if (!rst_n_v) begin
            mq.delete();
            m_fpc  = RESET_PC;
            m_busy = 1'b0;
        end else begin
            m_req = !m_busy && (mq.size() < DEPTH);
            acc   = m_req && rdy;
            if (cons && mq.size() > 0 && !redir) void'(mq.pop_front());
            if (rv) begin
                if (!m_stale && !redir) mq.push_back('{mem_fn(m_reqpc), m_reqpc + 32'd4});
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_lat--;
            end
            if (acc) begin
                m_busy  = 1'b1;
                m_stale = redir;
                m_reqpc = m_fpc;
                m_lat   = $urandom_range(0, lat_max);
            end
            if (redir) begin
                mq.delete();
                m_fpc = rpc;
                if (m_busy) m_stale = 1'b1;
            end else if (acc) begin
                m_fpc = m_fpc + 32'd4;
            end
        end
        e_i = (mq.size() != 0) ? mq[0].instr : 32'h0;
        e_p = (mq.size() != 0) ? mq[0].pcn   : 32'h0;
        compare_out("model", mq.size() != 0, e_i, e_p,
                    !m_busy && (mq.size() < DEPTH), m_fpc);
    endtask

    vec_t        vt[20];
    logic [31:0] seen[$];

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        consume     = 1'b0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        m_fpc       = RESET_PC;
        m_busy      = 1'b0;
        m_stale     = 1'b0;
        m_reqpc     = 32'h0;
        m_lat       = 0;
        lat_max     = 0;

        //        rst redir rpc         cons rdy rv rd            valid instr         pcn       req addr
        vt[0]  = '{0, 0, 32'h0,   0, 0, 0, 32'h0,         0, 32'h0,         32'h0,   1, 32'h0};
        vt[1]  = '{1, 0, 32'h0,   0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[2]  = '{1, 0, 32'h0,   0, 0, 1, 32'h2008_0005, 1, 32'h2008_0005, 32'h4,   1, 32'h4};
        vt[3]  = '{1, 0, 32'h0,   1, 1, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[4]  = '{1, 1, 32'h40,  0, 0, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[5]  = '{1, 0, 32'h0,   0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,   1, 32'h40};
        vt[6]  = '{1, 0, 32'h0,   0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[7]  = '{1, 1, 32'h80,  0, 0, 1, 32'h1111_1111, 0, 32'h0,         32'h0,   1, 32'h80};
        vt[8]  = '{1, 0, 32'h0,   0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[9]  = '{1, 0, 32'h0,   0, 0, 1, 32'h2222_2222, 1, 32'h2222_2222, 32'h84,  1, 32'h84};
        vt[10] = '{1, 0, 32'h0,   0, 1, 0, 32'h0,         1, 32'h2222_2222, 32'h84,  0, 32'h0};
        vt[11] = '{0, 0, 32'h0,   0, 0, 0, 32'h0,         0, 32'h0,         32'h0,   1, 32'h0};
        vt[12] = '{1, 0, 32'h0,   1, 0, 0, 32'h0,         0, 32'h0,         32'h0,   1, 32'h0};
        vt[13] = '{1, 1, 32'h100, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[14] = '{1, 0, 32'h0,   0, 0, 1, 32'h3333_3333, 0, 32'h0,         32'h0,   1, 32'h100};
        vt[15] = '{1, 0, 32'h0,   0, 1, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[16] = '{1, 1, 32'h200, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[17] = '{1, 1, 32'h300, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,   0, 32'h0};
        vt[18] = '{1, 0, 32'h0,   0, 0, 1, 32'h5555_5555, 0, 32'h0,         32'h0,   1, 32'h300};
        vt[19] = '{1, 0, 32'h0,   0, 0, 1, 32'h6666_6666, 0, 32'h0,         32'h0,   1, 32'h300};

        for (int i = 0; i < 20; i++) begin
            reset       = vt[i].rst_n;
            redirect    = vt[i].redir;
            redirect_pc = vt[i].rpc;
            consume     = vt[i].cons;
            mem_ready   = vt[i].rdy;
            mem_rvalid  = vt[i].rv;
            mem_rdata   = vt[i].rd;
            @(posedge clk);
            #1;
            compare_out($sformatf("table[%0d]", i), vt[i].e_valid, vt[i].e_instr,
                        vt[i].e_pcn, vt[i].e_req, vt[i].e_addr);
        end

        // Fill with no consumer, then one consume reopens the request at 0x10.
        lat_max = 0;
        tick(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 12; i++) tick(1, 0, 32'h0, 0, 1);
        chk("full_req_low", {31'h0, mem_req}, 32'h0);
        chk("full_head_pcn", out_pc_next, 32'h4);
        tick(1, 0, 32'h0, 1, 0);
        chk("reopen_req", {31'h0, mem_req}, 32'h1);
        chk("reopen_addr", mem_addr, 32'h10);

        // Consume continuously across the pointer wrap; order must be preserved.
        for (int i = 0; i < 14; i++) begin
            if (out_valid) seen.push_back(out_pc_next);
            tick(1, 0, 32'h0, 1, 1);
        end
        chk("wrap_seen_count", 32'(seen.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            chk($sformatf("wrap_order[%0d]", i), seen[i], 32'h8 + 32'(4 * i));
        end

        // Randomized traffic against the reference model.
        lat_max = 2;
        tick(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst;
            bit          r_red;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) != 0);
            r_red = ($urandom_range(0, 15) == 0);
            r_pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            tick(r_rst, r_red, r_pc, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
